// File: rtl/sprite_line_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_line_buffer_if
// Description : Sprite-renderer write channel into the scanline buffer.
//               valid/ready handshake carrying a back-bank pixel address and
//               pixel word.
//                 wr_valid  master->slave  write request
//                 wr_ready  slave->master  write accepted when valid & ready
//                 wr_addr   master->slave  back-bank pixel address
//                 wr_data   master->slave  pixel word ([3:0]=0 is transparent)
// Revision    : 1.0  initial release
// ============================================================================
interface sprite_line_buffer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/sprite_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_line_buffer
// Description : Double-buffered scanline store. Sprite pixels for the next
//               line are written into the back bank; the front bank is read
//               in step with the timing generator and cleared as it is read.
//               Banks swap on every hblank rise.
//   Ports:
//     clk, reset    clock, asynchronous active-high reset
//     cen           pixel clock enable
//     hblank        horizontal blank
//     video_pos_x   horizontal counter (visible span 256..511)
//     wr            write channel (sprite_line_buffer_if.slave)
//     pix_data      registered front-bank pixel, one cen after its address
//     pix_opaque    pix_data colour index non-zero
//     line_start    high for the cen clk on which the banks swap
//     bank_sel      current front (read) bank
// Revision    : 1.0  initial release
// ============================================================================
module sprite_line_buffer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  cen,
    input  wire logic                  hblank,
    input  wire logic [9:0]            video_pos_x,
    sprite_line_buffer_if.slave        wr,
    output logic      [DATA_WIDTH-1:0] pix_data,
    output logic                       pix_opaque,
    output logic                       line_start,
    output logic                       bank_sel
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic                  r_init;      // set by reset until hblank is first sampled
    logic                  r_hblank_d;
    logic                  r_bank_sel;
    logic [1:0]            r_primed;
    logic [DATA_WIDTH-1:0] r_pix_data;

    logic                  w_swap_pending;
    logic                  w_swap;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_wr_accept;
    logic [DATA_WIDTH-1:0] w_bank_rd [2];
    logic [DATA_WIDTH-1:0] w_front_rd;
    logic                  w_unused;

    // hblank_d holds its reset value of 0 until the first cen, so an edge is
    // only trusted once hblank has actually been sampled. This keeps an hblank
    // held high across reset release from looking like a rise.
    assign w_swap_pending = hblank & ~r_hblank_d & ~r_init;
    assign w_swap         = cen & w_swap_pending;

    assign w_rd_addr   = video_pos_x[ADDR_WIDTH-1:0];
    assign w_rd_en     = cen & ~hblank & video_pos_x[8];

    // Writes are refused while in reset and across the swap boundary so no
    // pixel can land in a bank whose role is changing.
    assign wr.wr_ready = ~r_init & ~w_swap_pending;
    assign w_wr_accept = wr.wr_valid & wr.wr_ready & (wr.wr_data[3:0] != 4'd0);

    // ------------------------------------------------------------------------
    // Two banks, one write port each. The front bank's port clears the
    // location being read; the back bank's port takes sprite writes.
    // ------------------------------------------------------------------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
        logic                  w_front;
        logic                  w_we;
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] w_data;

        assign w_front = (r_bank_sel == 1'(b));
        assign w_we    = w_front ? w_rd_en   : w_wr_accept;
        assign w_addr  = w_front ? w_rd_addr : wr.wr_addr;
        assign w_data  = w_front ? '0        : wr.wr_data;

        always_ff @(posedge clk) begin
            if (w_we) begin
                r_mem[w_addr] <= w_data;
            end
        end

        // Combinational read gives read-before-write on the clear cycle.
        assign w_bank_rd[b] = r_mem[w_rd_addr];
    end

    assign w_front_rd = r_bank_sel ? w_bank_rd[1] : w_bank_rd[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_init     <= 1'b1;
            r_hblank_d <= 1'b0;
            r_bank_sel <= 1'b0;
            r_primed   <= 2'b00;
            r_pix_data <= '0;
        end else if (cen) begin
            r_init     <= 1'b0;
            r_hblank_d <= hblank;
            if (w_swap) begin
                r_bank_sel           <= ~r_bank_sel;
                r_primed[~r_bank_sel] <= 1'b1;
            end
            // A bank that has never been a back bank since reset holds stale
            // RAM, so it reads as transparent for its first front line.
            if (w_rd_en) begin
                r_pix_data <= r_primed[r_bank_sel] ? w_front_rd : '0;
            end else begin
                r_pix_data <= '0;
            end
        end
    end

    assign pix_data   = r_pix_data;
    assign pix_opaque = (r_pix_data[3:0] != 4'd0);
    assign line_start = w_swap;
    assign bank_sel   = r_bank_sel;

    // Upper counter bits beyond the bank address are not needed.
    assign w_unused = ^video_pos_x;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_line_buffer
// Description : Directed bench for sprite_line_buffer. cen runs at half the
//               clk rate; each line is 256 visible pixels then a short blank.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sprite_line_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cen;
    logic       hblank;
    logic [9:0] video_pos_x;
    logic [7:0] pix_data;
    logic       pix_opaque;
    logic       line_start;
    logic       bank_sel;

    sprite_line_buffer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) wr_if ();

    sprite_line_buffer #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cen         (cen),
        .hblank      (hblank),
        .video_pos_x (video_pos_x),
        .wr          (wr_if),
        .pix_data    (pix_data),
        .pix_opaque  (pix_opaque),
        .line_start  (line_start),
        .bank_sel    (bank_sel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ls_count = 0;
    logic [7:0] exp_line [256];

    always @(negedge clk) begin
        if (line_start === 1'b1) ls_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 256; i++) exp_line[i] = 8'h00;
    endtask

    // One pixel-enable: cen high for one clk, then low for one clk.
    task automatic tick(input logic hb, input logic [9:0] x);
        @(posedge clk);
        #1;
        cen         = 1'b1;
        hblank      = hb;
        video_pos_x = x;
        @(posedge clk);
        #1;
        cen = 1'b0;
    endtask

    task automatic run_visible(input int stop);
        for (int i = 0; i < stop; i++) begin
            tick(1'b0, 10'(256 + i));
            check($sformatf("pix x=%0d", 256 + i), 32'(pix_data), 32'(exp_line[i]));
            check($sformatf("opaque x=%0d", 256 + i), 32'(pix_opaque), 32'(exp_line[i][3:0] != 4'd0));
        end
    endtask

    task automatic hblank_gap(input logic exp_bank);
        int ls0;
        ls0 = ls_count;
        tick(1'b1, 10'd512);
        check("bank_sel after swap", 32'(bank_sel), 32'(exp_bank));
        check("pix in hblank", 32'(pix_data), 32'h0);
        tick(1'b1, 10'd513);
        tick(1'b1, 10'd514);
        check("line_start once", 32'(ls_count - ls0), 32'd1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        int n;
        @(posedge clk);
        #1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = a;
        wr_if.wr_data  = d;
        #3;
        n = 0;
        while (wr_if.wr_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #4;
            n++;
        end
        check("wr_ready", 32'(wr_if.wr_ready), 32'd1);
        @(posedge clk);
        #1;
        wr_if.wr_valid = 1'b0;
    endtask

    // Continuous writes across an hblank rise; the rise coincides with cen.
    task automatic write_stream();
        int k;
        int ls0;
        k   = 0;
        ls0 = ls_count;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            cen            = (c == 4);
            hblank         = (c >= 4);
            video_pos_x    = 10'd512;
            wr_if.wr_valid = (k < 7);
            wr_if.wr_addr  = 8'(8'h20 + k);
            wr_if.wr_data  = 8'(8'h31 + k);
            #3;
            check($sformatf("stream ready c=%0d", c), 32'(wr_if.wr_ready), 32'(c != 4));
            if (wr_if.wr_ready === 1'b1 && wr_if.wr_valid) k++;
        end
        @(posedge clk);
        #1;
        cen            = 1'b0;
        wr_if.wr_valid = 1'b0;
        check("stream accepted", 32'(k), 32'd7);
        check("stream bank_sel", 32'(bank_sel), 32'd0);
        check("stream line_start", 32'(ls_count - ls0), 32'd1);
        tick(1'b1, 10'd513);
        tick(1'b1, 10'd514);
    endtask

    initial begin
        int ls0;
        reset          = 1'b1;
        cen            = 1'b0;
        hblank         = 1'b1;
        video_pos_x    = 10'd512;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = 8'h00;
        wr_if.wr_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset pix_data", 32'(pix_data), 32'h0);
        check("reset pix_opaque", 32'(pix_opaque), 32'h0);
        check("reset bank_sel", 32'(bank_sel), 32'h0);
        check("reset line_start", 32'(line_start), 32'h0);
        check("reset wr_ready", 32'(wr_if.wr_ready), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // hblank held high through reset release: no swap
        repeat (3) tick(1'b1, 10'd512);
        check("held hblank bank_sel", 32'(bank_sel), 32'h0);
        check("held hblank no line_start", 32'(ls_count), 32'h0);
        check("ready after init", 32'(wr_if.wr_ready), 32'd1);

        // Two swaps with no writes
        clear_exp();
        run_visible(256);
        hblank_gap(1'b1);
        run_visible(256);
        hblank_gap(1'b0);

        // Back bank is bank 1
        wr(8'h10, 8'h3A);
        wr(8'h11, 8'h50);
        wr(8'h05, 8'h21);
        wr(8'h05, 8'h42);
        run_visible(256);
        hblank_gap(1'b1);

        exp_line[8'h10] = 8'h3A;
        exp_line[8'h05] = 8'h42;
        run_visible(256);
        clear_exp();
        hblank_gap(1'b0);

        // Two more lines: bank 1 must have been cleared by its read-out
        run_visible(256);
        hblank_gap(1'b1);
        run_visible(256);
        write_stream();

        // Front bank 0 holds the pre-swap stream items
        exp_line[8'h20] = 8'h31;
        exp_line[8'h21] = 8'h32;
        exp_line[8'h22] = 8'h33;
        exp_line[8'h23] = 8'h34;
        run_visible(256);
        clear_exp();
        hblank_gap(1'b1);
        wr(8'h40, 8'h77);

        // Front bank 1 holds the post-swap items; reset hits at X=300
        exp_line[8'h24] = 8'h35;
        exp_line[8'h25] = 8'h36;
        exp_line[8'h26] = 8'h37;
        run_visible(44);
        clear_exp();
        #2;
        reset = 1'b1;
        #1;
        check("midline reset pix_data", 32'(pix_data), 32'h0);
        check("midline reset pix_opaque", 32'(pix_opaque), 32'h0);
        check("midline reset bank_sel", 32'(bank_sel), 32'h0);
        check("midline reset wr_ready", 32'(wr_if.wr_ready), 32'h0);
        @(posedge clk);
        #1;
        hblank      = 1'b1;
        video_pos_x = 10'd512;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ls0   = ls_count;
        repeat (2) tick(1'b1, 10'd512);
        check("post reset no swap", 32'(ls_count - ls0), 32'h0);
        check("post reset bank_sel", 32'(bank_sel), 32'h0);

        // Bank 0 has stale 0x77 at 0x40 but is unprimed
        run_visible(256);
        hblank_gap(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
